charlcd_4bit_responder: RTL and testbench

- Synthesizable HD44780-style device model: the display end of the 4-bit character-LCD bus driven by W0RM_Peripheral_CharLCD_4bit.
- Samples RS/RW/E/DB[7:4] and reassembles nibbles into bytes.
- Decodes the HD44780 command subset, tracks the address counter and busy timing, and answers bus reads.
- Used in benches and on FPGA loopback builds; exposes a decoded byte stream for checkers.

---
 rtl/charlcd_pkg.sv | 37 +++
 rtl/charlcd_bus_sync.sv | 61 ++++++
 rtl/charlcd_4bit_responder.sv | 185 ++++++++++++++++++
 tb/tb_charlcd_4bit_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charlcd_pkg.sv
// Shared definitions for the HD44780-style 4-bit bus responder: command
// opcode masks, instruction bit positions, nibble phase and the clear fill.
package charlcd_pkg;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_SETDD = 8'h80;

  localparam int DL_BIT = 4;
  localparam int ID_BIT = 1;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  typedef enum logic {PH_HIGH, PH_LOW} phase_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_OTHER, OP_FUNC, OP_SETDD
  } cmd_t;

  // The highest set bit selects the instruction; bits 6, 4 and 3 are
  // commands this model accepts without tracking any state.
  function automatic cmd_t cmd_decode(input logic [7:0] b);
    cmd_t c;
    c = OP_NOP;
    if (|(b & CMD_SETDD))      c = OP_SETDD;
    else if (b[6])             c = OP_OTHER;
    else if (|(b & CMD_FUNC))  c = OP_FUNC;
    else if (b[4] | b[3])      c = OP_OTHER;
    else if (|(b & CMD_ENTRY)) c = OP_ENTRY;
    else if (|(b & CMD_HOME))  c = OP_HOME;
    else if (|(b & CMD_CLEAR)) c = OP_CLEAR;
    return c;
  endfunction

endpackage

// File: rtl/charlcd_bus_sync.sv
// Bus front end: two-flop synchronisers on RS/RW/E/DB, falling-edge detect
// on synced E, and capture of RS/RW/DB on the detected edge.
module charlcd_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs_a,
  input  logic       rw_a,
  input  logic       e_a,
  input  logic [3:0] db_a,
  output logic       rs_sync,
  output logic       rw_sync,
  output logic       e_sync,
  output logic       vld_p2,
  output logic       rs_p2,
  output logic       rw_p2,
  output logic [3:0] nib_p2
);

  logic       rs_p0, rs_p1, rw_p0, rw_p1, e_p0, e_p1, e_dly;
  logic [3:0] db_p0, db_p1;
  logic       fall;

  // Stage p0/p1: synchronisers; e_dly keeps one more E sample for the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_p0 <= 1'b0; rs_p1 <= 1'b0;
      rw_p0 <= 1'b0; rw_p1 <= 1'b0;
      e_p0  <= 1'b0; e_p1  <= 1'b0; e_dly <= 1'b0;
      db_p0 <= 4'h0; db_p1 <= 4'h0;
    end else begin
      rs_p0 <= rs_a;  rs_p1 <= rs_p0;
      rw_p0 <= rw_a;  rw_p1 <= rw_p0;
      e_p0  <= e_a;   e_p1  <= e_p0;  e_dly <= e_p1;
      db_p0 <= db_a;  db_p1 <= db_p0;
    end
  end

  assign fall = e_dly & ~e_p1;

  // Stage p2: strobe plus the bus values captured on the falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      rs_p2  <= 1'b0;
      rw_p2  <= 1'b0;
      nib_p2 <= 4'h0;
    end else begin
      vld_p2 <= fall;
      if (fall) begin
        rs_p2  <= rs_p1;
        rw_p2  <= rw_p1;
        nib_p2 <= db_p1;
      end
    end
  end

  assign rs_sync = rs_p1;
  assign rw_sync = rw_p1;
  assign e_sync  = e_p1;

endmodule

// File: rtl/charlcd_4bit_responder.sv
// HD44780-style display end of a 4-bit character-LCD bus. Reassembles
// nibbles into bytes, decodes the command subset, tracks the address counter
// and busy time, answers busy-flag/data reads and reports each written byte.
// Optional macro CHARLCD_RESPONDER_DDRAM_EN adds a 2^ADDR_BITS x 8 DDRAM
// (needs CLEAR_CYCLES >= 2^ADDR_BITS for the clear fill to finish in time).
module charlcd_4bit_responder
  import charlcd_pkg::*;
#(
  parameter int ADDR_BITS    = 7,
  parameter int BUSY_CYCLES  = 20,
  parameter int CLEAR_CYCLES = 80
) (
  input  logic                 mem_clk,
  input  logic                 cpu_reset,
  input  logic                 lcd_bus_data_select,
  input  logic                 lcd_bus_read_write,
  input  logic                 lcd_bus_async_enable,
  input  logic [3:0]           lcd_bus_data_i,
  output logic [3:0]           lcd_bus_data_o,
  output logic                 lcd_bus_data_oe,
  output logic                 byte_valid_o,
  output logic                 byte_rs_o,
  output logic [7:0]           byte_data_o,
  output logic [ADDR_BITS-1:0] ddram_addr_o,
  output logic                 busy_o,
  output logic                 mode_4bit_o,
  output logic                 err_busy_o
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic                 rs_sync, rw_sync, e_sync;
  logic                 vld_p2, rs_p2, rw_p2;
  logic [3:0]           nib_p2;
  logic                 vld_p3, rs_p3, rw_p3;
  logic [7:0]           byte_p3;
  logic [3:0]           upper;
  phase_t               phase;
  logic [ADDR_BITS-1:0] addr, addr_step;
  logic                 inc, mode4;
  logic [CNT_W-1:0]     busy_cnt;
  cmd_t                 op;
  logic                 wr_cmd, wr_data, rd_data;
  logic [7:0]           ram_rd, rd_byte;

  charlcd_bus_sync u_sync (
    .clk     (mem_clk),
    .rst_n   (cpu_reset),
    .rs_a    (lcd_bus_data_select),
    .rw_a    (lcd_bus_read_write),
    .e_a     (lcd_bus_async_enable),
    .db_a    (lcd_bus_data_i),
    .rs_sync (rs_sync),
    .rw_sync (rw_sync),
    .e_sync  (e_sync),
    .vld_p2  (vld_p2),
    .rs_p2   (rs_p2),
    .rw_p2   (rw_p2),
    .nib_p2  (nib_p2)
  );

  // Stage p3: nibble assembly; a completed byte is decoded on the next cycle
  always_ff @(posedge mem_clk or negedge cpu_reset) begin
    if (!cpu_reset) begin
      vld_p3  <= 1'b0;
      rs_p3   <= 1'b0;
      rw_p3   <= 1'b0;
      byte_p3 <= 8'h00;
      phase   <= PH_HIGH;
    end else begin
      vld_p3 <= 1'b0;
      if (vld_p2) begin
        if (!mode4) begin
          vld_p3  <= 1'b1;
          rs_p3   <= rs_p2;
          rw_p3   <= rw_p2;
          byte_p3 <= {nib_p2, 4'h0};
        end else if (phase == PH_HIGH) begin
          phase <= PH_LOW;
        end else begin
          vld_p3  <= 1'b1;
          rs_p3   <= rs_p2;
          rw_p3   <= rw_p2;
          byte_p3 <= {upper, nib_p2};
          phase   <= PH_HIGH;
        end
      end
      // A function set in either direction realigns to the upper nibble
      if (wr_cmd && op == OP_FUNC) phase <= PH_HIGH;
    end
  end

  // Upper nibble holding register for 4-bit transfers
  always_ff @(posedge mem_clk) begin
    if (vld_p2 && mode4 && phase == PH_HIGH) upper <= nib_p2;
  end

  assign op        = cmd_decode(byte_p3);
  assign wr_cmd    = vld_p3 & ~rw_p3 & ~rs_p3;
  assign wr_data   = vld_p3 & ~rw_p3 &  rs_p3;
  assign rd_data   = vld_p3 &  rw_p3 &  rs_p3;
  assign addr_step = inc ? addr + 1'b1 : addr - 1'b1;

  // Address counter, entry direction and interface width
  always_ff @(posedge mem_clk or negedge cpu_reset) begin
    if (!cpu_reset) begin
      addr  <= '0;
      inc   <= 1'b1;
      mode4 <= 1'b0;
    end else if (wr_cmd) begin
      case (op)
        OP_SETDD: addr  <= ADDR_BITS'(byte_p3[6:0]);
        OP_FUNC:  mode4 <= ~byte_p3[DL_BIT];
        OP_ENTRY: inc   <= byte_p3[ID_BIT];
        OP_HOME:  addr  <= '0;
        OP_CLEAR: begin
          addr <= '0;
          inc  <= 1'b1;
        end
        default: ;
      endcase
    end else if (wr_data || rd_data) begin
      addr <= addr_step;
    end
  end

  // Busy countdown; any completed write reloads it, even while busy
  always_ff @(posedge mem_clk or negedge cpu_reset) begin
    if (!cpu_reset) begin
      busy_cnt <= '0;
    end else if (wr_cmd && (op == OP_CLEAR || op == OP_HOME)) begin
      busy_cnt <= CNT_W'(CLEAR_CYCLES);
    end else if (wr_data || (wr_cmd && op != OP_NOP)) begin
      busy_cnt <= CNT_W'(BUSY_CYCLES);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

`ifdef CHARLCD_RESPONDER_DDRAM_EN
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           ram [DEPTH];
  logic                 fill_act;
  logic [ADDR_BITS-1:0] fill_idx;

  // Clear walks every location once, starting the cycle after decode
  always_ff @(posedge mem_clk or negedge cpu_reset) begin
    if (!cpu_reset) begin
      fill_act <= 1'b0;
      fill_idx <= '0;
    end else if (wr_cmd && op == OP_CLEAR) begin
      fill_act <= 1'b1;
      fill_idx <= '0;
    end else if (fill_act) begin
      fill_idx <= fill_idx + 1'b1;
      if (fill_idx == '1) fill_act <= 1'b0;
    end
  end

  // Display data storage; a data write takes precedence over the fill
  always_ff @(posedge mem_clk) begin
    if (wr_data)       ram[addr]     <= byte_p3;
    else if (fill_act) ram[fill_idx] <= FILL_CHAR;
  end

  assign ram_rd = ram[addr];
`else
  assign ram_rd = 8'h00;
`endif

  assign rd_byte         = rs_sync ? ram_rd : {busy_o, 7'(addr)};
  assign lcd_bus_data_o  = (phase == PH_HIGH) ? rd_byte[7:4] : rd_byte[3:0];
  assign lcd_bus_data_oe = e_sync & rw_sync;

  assign byte_valid_o = vld_p3 & ~rw_p3;
  assign byte_rs_o    = rs_p3;
  assign byte_data_o  = byte_p3;
  assign ddram_addr_o = addr;
  assign busy_o       = (busy_cnt != '0);
  assign mode_4bit_o  = mode4;
  assign err_busy_o   = byte_valid_o & busy_o;

endmodule

// File: tb/tb_charlcd_4bit_responder.sv
// Bench for charlcd_4bit_responder: directed steps followed by randomized
// bus transfers, all checked against a transaction-level display model.
module tb_charlcd_4bit_responder;

`ifdef CHARLCD_RESPONDER_DDRAM_EN
  localparam int CLR = 128;
`else
  localparam int CLR = 80;
`endif
  localparam int BUSY = 20;

  logic       mem_clk = 1'b0;
  logic       cpu_reset = 1'b0;
  logic       rs_i = 1'b0, rw_i = 1'b0, e_i = 1'b0;
  logic [3:0] db_i = 4'h0;
  logic [3:0] lcd_bus_data_o;
  logic       lcd_bus_data_oe, byte_valid_o, byte_rs_o, busy_o, mode_4bit_o, err_busy_o;
  logic [7:0] byte_data_o;
  logic [6:0] ddram_addr_o;

  always #5 mem_clk = ~mem_clk;

  charlcd_4bit_responder #(.ADDR_BITS(7), .BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR)) dut (
    .mem_clk(mem_clk), .cpu_reset(cpu_reset),
    .lcd_bus_data_select(rs_i), .lcd_bus_read_write(rw_i),
    .lcd_bus_async_enable(e_i), .lcd_bus_data_i(db_i),
    .lcd_bus_data_o(lcd_bus_data_o), .lcd_bus_data_oe(lcd_bus_data_oe),
    .byte_valid_o(byte_valid_o), .byte_rs_o(byte_rs_o), .byte_data_o(byte_data_o),
    .ddram_addr_o(ddram_addr_o), .busy_o(busy_o), .mode_4bit_o(mode_4bit_o),
    .err_busy_o(err_busy_o)
  );

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, bv_cnt = 0, bv_cyc = 0, err_cnt = 0, run = 0, last_run = 0;
  logic [7:0] bv_data = 8'h00;
  logic       bv_rs = 1'b0;

  // Output monitor: byte log, error pulses and length of each busy interval
  always @(negedge mem_clk) begin
    cyc = cyc + 1;
    if (byte_valid_o) begin
      bv_cnt = bv_cnt + 1; bv_cyc = cyc; bv_data = byte_data_o; bv_rs = byte_rs_o;
    end
    if (err_busy_o) err_cnt = err_cnt + 1;
    if (busy_o) run = run + 1;
    else if (run != 0) begin last_run = run; run = 0; end
  end

  // Display model, kept at byte/transaction level
  bit         m_mode4, m_phase_hi, m_inc, m_clr;
  logic [3:0] m_upper;
  logic [6:0] m_addr;
  logic [7:0] m_mem [128];

  task automatic model_reset();
    m_mode4 = 0; m_phase_hi = 1; m_inc = 1; m_addr = 7'd0; m_upper = 4'h0; m_clr = 0;
  endtask

  function automatic logic [7:0] m_rd_data();
`ifdef CHARLCD_RESPONDER_DDRAM_EN
    return m_mem[m_addr];
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_nib(input logic [3:0] d, output bit done, output logic [7:0] b);
    done = 0; b = 8'h00;
    if (!m_mode4) begin done = 1; b = {d, 4'h0}; end
    else if (m_phase_hi) begin m_upper = d; m_phase_hi = 0; end
    else begin done = 1; b = {m_upper, d}; m_phase_hi = 1; end
  endtask

  task automatic model_effect(input bit rs, input bit rw, input logic [7:0] b);
    m_clr = 0;
    if (rw) begin
      if (rs) m_addr = m_inc ? m_addr + 7'd1 : m_addr - 7'd1;
    end else if (rs) begin
      m_mem[m_addr] = b;
      m_addr = m_inc ? m_addr + 7'd1 : m_addr - 7'd1;
    end else if (b >= 8'h80) m_addr = b[6:0];
    else if (b >= 8'h40) ;
    else if (b >= 8'h20) begin m_mode4 = !b[4]; m_phase_hi = 1; end
    else if (b >= 8'h08) ;
    else if (b >= 8'h04) m_inc = b[1];
    else if (b >= 8'h02) m_addr = 7'd0;
    else if (b == 8'h01) begin
      m_addr = 7'd0; m_inc = 1; m_clr = 1;
      for (int k = 0; k < 128; k++) m_mem[k] = 8'h20;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge mem_clk); #1;
      if (!busy_o) ok = 1;
    end
    n_cmp++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL idle_wait: busy_o observed %0d after 400 cycles, expected 0", busy_o);
    end
  endtask

  // One E strobe; the read bus is sampled while E is high
  task automatic bus_nib(input bit rs, input bit rw, input logic [3:0] d,
                         output logic [3:0] obs_nib, output logic obs_oe);
    @(negedge mem_clk); rs_i = rs; rw_i = rw; db_i = d;
    @(negedge mem_clk); e_i = 1'b1;
    repeat (4) @(negedge mem_clk);
    #1; obs_nib = lcd_bus_data_o; obs_oe = lcd_bus_data_oe;
    @(negedge mem_clk); e_i = 1'b0;
    repeat (8) @(negedge mem_clk);
    #1;
  endtask

  // One byte transfer in whatever width the model says the interface is
  task automatic byte_xfer(input bit rs, input bit rw, input logic [7:0] b, input bit busy_exp);
    int n, c0;
    logic [3:0] d, obs_nib, exp_nib;
    logic [7:0] rdb, cb;
    logic obs_oe;
    bit done;
    n = m_mode4 ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? b[7:4] : b[3:0];
      rdb = rs ? m_rd_data() : {busy_exp, m_addr};
      exp_nib = m_phase_hi ? rdb[7:4] : rdb[3:0];
      c0 = bv_cnt;
      bus_nib(rs, rw, d, obs_nib, obs_oe);
      model_nib(d, done, cb);
      if (done) model_effect(rs, rw, cb);
      if (rw) begin
        check("rd_oe", 32'(obs_oe), 1);
        check("rd_nibble", 32'(obs_nib), 32'(exp_nib));
        check("rd_no_valid", bv_cnt, c0);
      end else begin
        check("wr_valid_count", bv_cnt, c0 + (done ? 1 : 0));
        if (done) begin
          check("wr_byte", 32'(bv_data), 32'(cb));
          check("wr_rs", 32'(bv_rs), 32'(rs));
        end
      end
      check("oe_after_e", 32'(lcd_bus_data_oe), 0);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, e0, ops;
    bit rs, rw;
    logic [7:0] b;
    model_reset();
    for (int k = 0; k < 128; k++) m_mem[k] = 8'h20;

    // Reset state
    repeat (3) @(negedge mem_clk);
    #1;
    check("rst_valid", 32'(byte_valid_o), 0);
    check("rst_oe", 32'(lcd_bus_data_oe), 0);
    check("rst_data_o", 32'(lcd_bus_data_o), 0);
    check("rst_addr", 32'(ddram_addr_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_mode", 32'(mode_4bit_o), 0);
    check("rst_err", 32'(err_busy_o), 0);
    @(negedge mem_clk); cpu_reset = 1'b1;
    repeat (2) @(negedge mem_clk);

    // 8-bit function set into 4-bit mode
    byte_xfer(0, 0, 8'h20, 0);
    check("func_byte", 32'(bv_data), 32'h20);
    check("mode_4bit", 32'(mode_4bit_o), 1);
    wait_idle();
    check("busy_len", last_run, BUSY);

    // 4-bit set address then data write
    byte_xfer(0, 0, 8'h85, 0);
    check("setdd_addr", 32'(ddram_addr_o), 32'h05);
    byte_xfer(1, 0, 8'h41, 0);
    check("data_byte", 32'(bv_data), 32'h41);
    check("data_addr", 32'(ddram_addr_o), 32'h06);

    // Address wrap both directions
    byte_xfer(0, 0, 8'hFF, 0);
    check("setdd_7f", 32'(ddram_addr_o), 32'h7F);
    byte_xfer(0, 0, 8'h06, 0);
    byte_xfer(1, 0, 8'h33, 0);
    check("wrap_up", 32'(ddram_addr_o), 32'h00);
    byte_xfer(0, 0, 8'h04, 0);
    byte_xfer(1, 0, 8'h34, 0);
    check("wrap_down", 32'(ddram_addr_o), 32'h7F);
    check("model_addr", 32'(ddram_addr_o), 32'(m_addr));

    // Clear, then a write while still busy
    wait_idle();
    e0 = err_cnt;
    byte_xfer(0, 0, 8'h01, 0);
    t1 = bv_cyc;
    check("clear_addr", 32'(ddram_addr_o), 0);
    check("clear_busy", 32'(busy_o), 1);
    check("clear_no_err", err_cnt, e0);
    byte_xfer(1, 0, 8'h55, 0);
    t2 = bv_cyc;
    check("err_pulse", err_cnt, e0 + 1);
    check("clear_inc_reset", 32'(ddram_addr_o), 32'h01);
    wait_idle();
    check("busy_reload_len", last_run, t2 + BUSY - t1);

    // Busy-flag read while busy, then after idle
    wait_idle();
    byte_xfer(0, 0, 8'hAA, 0);
    byte_xfer(0, 1, 8'h00, 1);
    check("bf_read_addr", 32'(ddram_addr_o), 32'h2A);
    wait_idle();
    byte_xfer(0, 1, 8'h00, 0);

`ifdef CHARLCD_RESPONDER_DDRAM_EN
    // DDRAM write, readback and clear fill
    byte_xfer(0, 0, 8'h90, 0);
    byte_xfer(1, 0, 8'h41, 0);
    check("ram_wr_addr", 32'(ddram_addr_o), 32'h11);
    byte_xfer(0, 0, 8'h90, 0);
    wait_idle();
    byte_xfer(1, 1, 8'h00, 0);
    check("ram_rd_addr", 32'(ddram_addr_o), 32'h11);
    check("ram_model", 32'(m_mem[7'h10]), 32'h41);
    byte_xfer(0, 0, 8'h01, 0);
    wait_idle();
    byte_xfer(1, 1, 8'h00, 0);
`endif

    // Randomized writes and reads
    for (ops = 0; ops < 50; ops++) begin
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 9) < 3);
      b  = 8'($urandom);
      if (rw) begin
        wait_idle();
        byte_xfer(rs, 1, 8'h00, 0);
      end else begin
        byte_xfer(rs, 0, b, 0);
        if (m_clr) wait_idle();
      end
      check("rand_addr", 32'(ddram_addr_o), 32'(m_addr));
      check("rand_mode", 32'(mode_4bit_o), 32'(m_mode4));
      repeat ($urandom_range(0, 20)) @(negedge mem_clk);
    end

    // Reset in the middle of a 4-bit transfer
    byte_xfer(0, 0, 8'h28, 0);
    wait_idle();
    @(negedge mem_clk); rs_i = 1'b1; rw_i = 1'b0; db_i = 4'h4;
    @(negedge mem_clk); e_i = 1'b1;
    repeat (4) @(negedge mem_clk);
    cpu_reset = 1'b0;
    e0 = bv_cnt;
    @(negedge mem_clk); #1;
    check("midrst_mode", 32'(mode_4bit_o), 0);
    check("midrst_oe", 32'(lcd_bus_data_oe), 0);
    check("midrst_busy", 32'(busy_o), 0);
    e_i = 1'b0;
    repeat (2) @(negedge mem_clk);
    cpu_reset = 1'b1;
    repeat (10) @(negedge mem_clk);
    #1;
    check("midrst_no_byte", bv_cnt, e0);
    check("midrst_addr", 32'(ddram_addr_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
